// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
// Shared types and constants for the multi-cycle shifter controller.
//   op_e        : shift operation encoding (10 is a reserved code treated as SLL)
//   state_e     : controller FSM states
//   STEP_MAX_DEFAULT : default per-cycle shift distance
//   clamp_step  : min(remaining, max_step) in 5-bit arithmetic
//   op_is_right : true for the right-shifting operations
// ----------------------------------------------------------------------------
package shift_pkg;

   localparam int DATA_W           = 32;
   localparam int AMT_W            = 5;
   localparam int STEP_MAX_DEFAULT = 7;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_RSV = 2'b10,
      OP_SRA = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic logic [AMT_W-1:0] clamp_step(input logic [AMT_W-1:0] rem,
                                                   input logic [AMT_W-1:0] max_step);
      return (rem < max_step) ? rem : max_step;
   endfunction

   function automatic logic op_is_right(input op_e op);
      return (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// shift_seq_ctrl_if
// Request/response bundle of the shifter controller.
//   Request : i_valid/o_ready handshake, i_data, i_shift_amt, i_op
//   Control : i_flush (synchronous abort)
//   Result  : o_valid/i_ready handshake, o_data
//   Status  : o_busy
// Signal names are seen from the controller: i_* flow into it, o_* out of it.
//   slave  : the controller side
//   master : the requester / consumer side
// ----------------------------------------------------------------------------
interface shift_seq_ctrl_if;
   import shift_pkg::*;

   logic                i_valid;
   logic                o_ready;
   logic [DATA_W-1:0]   i_data;
   logic [AMT_W-1:0]    i_shift_amt;
   logic [1:0]          i_op;
   logic                i_flush;
   logic                o_valid;
   logic                i_ready;
   logic [DATA_W-1:0]   o_data;
   logic                o_busy;

   modport slave (
      input  i_valid, i_data, i_shift_amt, i_op, i_flush, i_ready,
      output o_ready, o_valid, o_data, o_busy
   );

   modport master (
      output i_valid, i_data, i_shift_amt, i_op, i_flush, i_ready,
      input  o_ready, o_valid, o_data, o_busy
   );

endinterface

// File: rtl/shift_step.sv
// ----------------------------------------------------------------------------
// shift_step
// Combinational single-step shifter: shifts data by 0..STEP_MAX positions.
//   data      : 32-bit operand
//   step      : shift distance for this step (values above STEP_MAX pass data through)
//   dir_right : 1 = shift right, 0 = shift left
//   fill      : bit shifted in from the top on right shifts (sign for SRA)
//   result    : shifted value
// Left shifts always fill with zero.
// ----------------------------------------------------------------------------
module shift_step
   import shift_pkg::*;
#(
   parameter int STEP_MAX = STEP_MAX_DEFAULT
) (
   input  logic [DATA_W-1:0] data,
   input  logic [AMT_W-1:0]  step,
   input  logic              dir_right,
   input  logic              fill,
   output logic [DATA_W-1:0] result
);

   // One candidate per legal step distance; only STEP_MAX+1 shifters are
   // needed because the controller never asks for more than STEP_MAX.
   logic [DATA_W-1:0] cand [0:STEP_MAX];

   for (genvar gi = 0; gi <= STEP_MAX; gi++) begin : g_cand
      assign cand[gi] = dir_right ? DATA_W'({{DATA_W{fill}}, data} >> gi)
                                  : (data << gi);
   end

   always_comb begin
      result = data;
      for (int k = 0; k <= STEP_MAX; k++) begin
         if (step == AMT_W'(k)) begin
            result = cand[k];
         end
      end
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// ----------------------------------------------------------------------------
// shift_seq_ctrl
// Multi-cycle shifter controller. Accepts one request at a time, shifts the
// operand by at most STEP_MAX positions per clock until the requested
// distance is covered, then presents the result until it is consumed.
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-high reset
//   bus     : shift_seq_ctrl_if.slave (request, flush, result, busy)
// FSM: IDLE (accepting) -> SHIFT (stepping) -> DONE (holding result) -> IDLE.
// i_flush returns to IDLE from any state and wins over everything else.
// ----------------------------------------------------------------------------
module shift_seq_ctrl
   import shift_pkg::*;
#(
   parameter int STEP_MAX = STEP_MAX_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_reset,
   shift_seq_ctrl_if.slave  bus
);

   localparam logic [AMT_W-1:0] STEP_MAX_C = AMT_W'(STEP_MAX);

   state_e             state_reg;
   logic [DATA_W-1:0]  data_reg;
   logic [AMT_W-1:0]   rem_reg;
   op_e                op_reg;
   logic               sign_reg;
   logic               valid_reg;
   logic               ready_reg;
   logic               busy_reg;

   logic [AMT_W-1:0]   step;
   logic [DATA_W-1:0]  step_result;
   logic               dir_right;
   logic               fill;

   // Step size never exceeds what is left, so rem_reg - step cannot wrap.
   assign step      = clamp_step(rem_reg, STEP_MAX_C);
   assign dir_right = op_is_right(op_reg);
   // SRA fills with the operand's original sign, captured at acceptance.
   assign fill      = (op_reg == OP_SRA) ? sign_reg : 1'b0;

   shift_step #(
      .STEP_MAX (STEP_MAX)
   ) u_step (
      .data      (data_reg),
      .step      (step),
      .dir_right (dir_right),
      .fill      (fill),
      .result    (step_result)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg <= ST_IDLE;
         data_reg  <= '0;
         rem_reg   <= '0;
         op_reg    <= OP_SLL;
         sign_reg  <= 1'b0;
         valid_reg <= 1'b0;
         ready_reg <= 1'b1;
         busy_reg  <= 1'b0;
      end else if (bus.i_flush) begin
         // Abort: result discarded, data_reg left as-is (meaningless without o_valid).
         state_reg <= ST_IDLE;
         valid_reg <= 1'b0;
         ready_reg <= 1'b1;
         busy_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.i_valid) begin
                  data_reg  <= bus.i_data;
                  op_reg    <= op_e'(bus.i_op);
                  rem_reg   <= bus.i_shift_amt;
                  sign_reg  <= bus.i_data[DATA_W-1];
                  ready_reg <= 1'b0;
                  busy_reg  <= 1'b1;
                  if (bus.i_shift_amt == '0) begin
                     state_reg <= ST_DONE;
                     valid_reg <= 1'b1;
                  end else begin
                     state_reg <= ST_SHIFT;
                  end
               end
            end

            ST_SHIFT: begin
               data_reg <= step_result;
               rem_reg  <= rem_reg - step;
               if (rem_reg == step) begin
                  state_reg <= ST_DONE;
                  valid_reg <= 1'b1;
               end
            end

            ST_DONE: begin
               if (bus.i_ready) begin
                  state_reg <= ST_IDLE;
                  valid_reg <= 1'b0;
                  ready_reg <= 1'b1;
                  busy_reg  <= 1'b0;
               end
            end

            default: begin
               state_reg <= ST_IDLE;
               valid_reg <= 1'b0;
               ready_reg <= 1'b1;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_ready = ready_reg;
   assign bus.o_valid = valid_reg;
   assign bus.o_busy  = busy_reg;
   assign bus.o_data  = data_reg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_shift_seq_ctrl
// Self-checking bench for shift_seq_ctrl (STEP_MAX = 7).
// Expected results and latencies are pushed to a scoreboard queue when a
// request is driven and popped when the DUT raises o_valid.
// ----------------------------------------------------------------------------
module tb_shift_seq_ctrl;

   localparam int STEP = 7;

   typedef struct {
      logic [31:0] data;
      int          lat;
   } exp_t;

   logic clk;
   logic rst;
   int   tests_run;
   int   fails;
   exp_t sb[$];

   shift_seq_ctrl_if bus();

   shift_seq_ctrl #(
      .STEP_MAX (STEP)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] amt,
                                         input logic [1:0] op);
      logic signed [31:0] s;
      s = d;
      case (op)
         2'b01:   return d >> amt;
         2'b11:   return $unsigned(s >>> amt);
         default: return d << amt;
      endcase
   endfunction

   function automatic int exp_lat(input logic [4:0] amt);
      if (amt == 5'd0) return 0;
      return (int'(amt) + STEP - 1) / STEP;
   endfunction

   // Runs one full transaction; hold = cycles to keep i_ready low in DONE.
   task automatic run_op(input logic [31:0] d, input logic [4:0] amt, input logic [1:0] op,
                         input int hold, input string name);
      exp_t e;
      exp_t got;
      int   cnt;
      int   wait_cnt;
      e.data = model(d, amt, op);
      e.lat  = exp_lat(amt);
      wait_cnt = 0;
      while (bus.o_ready !== 1'b1 && wait_cnt < 50) begin
         @(posedge clk); #1;
         wait_cnt++;
      end
      tests_run++;
      if (bus.o_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s ready_wait: o_ready=%b required 1", name, bus.o_ready);
         return;
      end
      bus.i_valid     = 1'b1;
      bus.i_data      = d;
      bus.i_shift_amt = amt;
      bus.i_op        = op;
      bus.i_ready     = (hold == 0);
      sb.push_back(e);
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      tests_run++;
      if (bus.o_ready !== 1'b0 || bus.o_busy !== 1'b1) begin
         fails++;
         $display("FAIL %s accepted: o_ready=%b o_busy=%b required 0/1", name, bus.o_ready, bus.o_busy);
      end
      cnt = 0;
      while (bus.o_valid !== 1'b1 && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      got = sb.pop_front();
      tests_run++;
      if (bus.o_valid !== 1'b1 || cnt != got.lat) begin
         fails++;
         $display("FAIL %s latency: o_valid=%b after %0d edges, required 1 after %0d",
                  name, bus.o_valid, cnt, got.lat);
      end
      tests_run++;
      if (bus.o_data !== got.data) begin
         fails++;
         $display("FAIL %s data: o_data=%h required %h", name, bus.o_data, got.data);
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         tests_run++;
         if (bus.o_valid !== 1'b1 || bus.o_data !== got.data || bus.o_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s hold%0d: valid=%b data=%h ready=%b required 1/%h/0",
                     name, i, bus.o_valid, bus.o_data, bus.o_ready, got.data);
         end
      end
      bus.i_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_ready = 1'b0;
      tests_run++;
      if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
         fails++;
         $display("FAIL %s release: valid=%b ready=%b busy=%b required 0/1/0",
                  name, bus.o_valid, bus.o_ready, bus.o_busy);
      end
      $display("[TB] txn %s: op=%b data=%h amt=%0d -> %h (lat %0d, hold %0d)",
               name, op, d, amt, got.data, got.lat, hold);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_flags: ready=%b valid=%b busy=%b required 1/0/0",
                  bus.o_ready, bus.o_valid, bus.o_busy);
      end
      tests_run++;
      if (bus.o_data !== 32'h0) begin
         fails++;
         $display("FAIL reset_data: o_data=%h required 00000000", bus.o_data);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: ready=%b busy=%b required 1/0", bus.o_ready, bus.o_busy);
      end
   endtask

   task automatic test_basic();
      run_op(32'h0000_0001, 5'd31, 2'b00, 0, "sll31");
      run_op(32'h8000_0000, 5'd31, 2'b11, 0, "sra31");
      run_op(32'h8000_0000, 5'd8,  2'b01, 0, "srl8");
      run_op(32'h0000_000F, 5'd4,  2'b10, 0, "op10_4");
      run_op(32'hF0F0_1234, 5'd7,  2'b11, 0, "sra7");
      run_op(32'h7000_0001, 5'd14, 2'b11, 0, "sra14_pos");
      run_op(32'hA5A5_5A5A, 5'd1,  2'b01, 0, "srl1");
   endtask

   task automatic test_zero_amt();
      run_op(32'hDEAD_BEEF, 5'd0, 2'b00, 0, "zero_sll");
      run_op(32'hDEAD_BEEF, 5'd0, 2'b01, 0, "zero_srl");
      run_op(32'hDEAD_BEEF, 5'd0, 2'b10, 0, "zero_op10");
      run_op(32'hDEAD_BEEF, 5'd0, 2'b11, 0, "zero_sra");
   endtask

   task automatic test_backpressure();
      run_op(32'h1234_5678, 5'd12, 2'b01, 3, "bp3");
      run_op(32'hCAFE_0000, 5'd0,  2'b11, 2, "bp_zero");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         run_op($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 2), $sformatf("rand%0d", i));
      end
   endtask

   task automatic test_flush();
      int seen;
      bus.i_valid     = 1'b1;
      bus.i_data      = 32'h1234_5678;
      bus.i_shift_amt = 5'd20;
      bus.i_op        = 2'b00;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (bus.o_busy !== 1'b1) begin
         fails++;
         $display("FAIL flush_pre: o_busy=%b required 1", bus.o_busy);
      end
      bus.i_flush = 1'b1;
      @(posedge clk); #1;
      bus.i_flush = 1'b0;
      tests_run++;
      if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
         fails++;
         $display("FAIL flush_shift: busy=%b ready=%b valid=%b required 0/1/0",
                  bus.o_busy, bus.o_ready, bus.o_valid);
      end
      // Flush in IDLE with a pending request must block acceptance.
      bus.i_valid = 1'b1;
      bus.i_flush = 1'b1;
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) seen++;
      end
      bus.i_valid = 1'b0;
      bus.i_flush = 1'b0;
      tests_run++;
      if (seen != 0) begin
         fails++;
         $display("FAIL flush_idle: %0d cycles with acceptance, required 0", seen);
      end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (bus.o_valid === 1'b1) seen++;
      end
      tests_run++;
      if (seen != 0) begin
         fails++;
         $display("FAIL flush_novalid: o_valid high %0d cycles, required 0", seen);
      end
      // Flush while holding a result in DONE.
      bus.i_valid     = 1'b1;
      bus.i_data      = 32'h0000_00FF;
      bus.i_shift_amt = 5'd0;
      bus.i_op        = 2'b01;
      bus.i_ready     = 1'b0;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      bus.i_flush = 1'b1;
      @(posedge clk); #1;
      bus.i_flush = 1'b0;
      tests_run++;
      if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
         fails++;
         $display("FAIL flush_done: valid=%b ready=%b busy=%b required 0/1/0",
                  bus.o_valid, bus.o_ready, bus.o_busy);
      end
      $display("[TB] txn flush: shift/idle/done aborts exercised");
   endtask

   task automatic test_reset_mid();
      bus.i_valid     = 1'b1;
      bus.i_data      = 32'hFFFF_0000;
      bus.i_shift_amt = 5'd31;
      bus.i_op        = 2'b00;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      @(posedge clk); #1;
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_data !== 32'h0) begin
         fails++;
         $display("FAIL reset_mid: busy=%b ready=%b valid=%b data=%h required 0/1/0/00000000",
                  bus.o_busy, bus.o_ready, bus.o_valid, bus.o_data);
      end
      #1;
      rst = 1'b0;
      $display("[TB] txn reset_mid: operation aborted by reset");
      run_op(32'h0000_0100, 5'd4, 2'b01, 0, "post_reset_srl4");
   endtask

   initial begin
      tests_run       = 0;
      fails           = 0;
      rst             = 1'b1;
      bus.i_valid     = 1'b0;
      bus.i_data      = '0;
      bus.i_shift_amt = '0;
      bus.i_op        = '0;
      bus.i_flush     = 1'b0;
      bus.i_ready     = 1'b0;

      test_reset();
      test_basic();
      test_zero_amt();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_reset_mid();

      tests_run++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter STEP_MAX, default 7, meaning the maximum shift distance applied per cycle (legal range 1..31).
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port i_valid, input, 1 bit: request valid.
REQ-005 SHALL have port o_ready, output, 1 bit: request accepted on any edge where i_valid && o_ready.
REQ-006 SHALL have port i_data, input, 32 bits: operand.
REQ-007 SHALL have port i_shift_amt, input, 5 bits: shift distance 0..31.
REQ-008 SHALL have port i_op, input, 2 bits: 00 SLL, 01 SRL, 11 SRA, 10 treated as SLL.
REQ-009 SHALL have port i_flush, input, 1 bit: synchronous abort of any operation in flight.
REQ-010 SHALL have port o_valid, output, 1 bit: result valid.
REQ-011 SHALL have port i_ready, input, 1 bit: result consumed on any edge where o_valid && i_ready.
REQ-012 SHALL have port o_data, output, 32 bits: shifted result.
REQ-013 SHALL have port o_busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-015 SHALL drive o_ready high only in IDLE and low in SHIFT and DONE; there is no back-to-back acceptance.
REQ-016 On acceptance SHALL register the operand, op and remaining count = i_shift_amt; go to DONE if i_shift_amt==0, else to SHIFT.
REQ-017 In SHIFT, each edge SHALL apply step = min(remaining, STEP_MAX) to the data register and set remaining -= step; on reaching 0, go to DONE.
REQ-018 SHALL fill vacated bits with 0 for SLL/SRL and with the original bit 31 for SRA; SRA sign is held constant across steps.
REQ-019 SHALL make o_valid rise exactly ceil(amt/STEP_MAX) edges after the acceptance edge (0 for amt=0, i.e. the next cycle).
REQ-020 In DONE SHALL hold o_valid high and o_data stable until i_ready; on handshake, go to IDLE with o_valid low the next cycle.
REQ-021 SHALL drive o_data with the data register in all states; the value is meaningful only while o_valid is high.
REQ-022 i_flush SHALL force IDLE on the next edge from any state, with priority over acceptance, stepping and completion; the result is discarded and o_valid is low the next cycle.
REQ-023 i_flush in IDLE with i_valid high SHALL suppress acceptance; o_ready stays high.
REQ-024 Remaining-count arithmetic SHALL be 5-bit unsigned and never underflow.

Reset
REQ-025 i_reset high SHALL immediately set: state IDLE, o_valid 0, o_busy 0, o_ready 1, data register 0, remaining 0, op SLL.
REQ-026 Reset asserted mid-operation SHALL discard the operation with no partial result emitted; the first acceptance is possible on the first edge after deassertion.

Structure
REQ-027 Package shift_pkg SHALL hold the op encoding enum, the FSM state enum and the default STEP_MAX constant.
REQ-028 Sub-module shift_step SHALL be a combinational unit: 32-bit data, step 0..STEP_MAX, direction, fill bit -> 32-bit result; instantiated once.

Verification
REQ-029 SLL 0x00000001 by 31, i_ready=1 -> o_data 0x80000000, o_valid 5 edges after acceptance.
REQ-030 SRA 0x80000000 by 31 -> 0xFFFFFFFF; SRL 0x80000000 by 8 -> 0x00800000 after 2 edges.
REQ-031 Any op with amt 0, data 0xDEADBEEF -> 0xDEADBEEF with o_valid on the next cycle; op 10 by 4 on 0x0000000F -> 0x000000F0.
REQ-032 DONE with i_ready low for 3 cycles -> o_valid and o_data held, o_ready low; completes on the 4th cycle's handshake.
REQ-033 i_flush during SHIFT (amt 20) -> IDLE next edge, o_valid never rises; i_valid held high during IDLE+flush -> no acceptance.
REQ-034 i_reset pulsed mid-SHIFT, between edges -> o_busy drops immediately; new SRL 0x100 by 4 afterwards -> 0x10.
